// File: rtl/lzc.sv
// Pipelined leading-zero counter built from a binary tree of 2-bit LZ/all-zero cells.
// Define LZC_PIPE_EN to register the midpoint tree level, which raises the latency from 1 to 2 cycles.
module lzc #(
    parameter int W     = 12,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             valid_i,
    input  logic [W-1:0]     data_i,
    output logic             valid_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    localparam int LOG2P = (W <= 2) ? 1 : $clog2(W);
    localparam int P     = 1 << LOG2P;
    localparam int S     = (LOG2P + 1) / 2;
    localparam int CW    = LOG2P + 1;
    localparam int NB    = LOG2P - S + 1;

    logic [P-1:0]  padded;
    logic          f_zf   [S+1][P];
    logic [CW-1:0] f_cn   [S+1][P];
    logic          mid_zf [P];
    logic [CW-1:0] mid_cn [P];
    logic          b_zf   [NB][P];
    logic [CW-1:0] b_cn   [NB][P];
    logic          stage_valid;
    logic [CW-1:0] cnt_full;

    // Ones below the LSB end every scan inside the real W bits.
    // An all-zero input therefore still counts exactly W.
    always_comb begin
        padded = '1;
        padded[P-1 -: W] = data_i;
    end

    // Node cnt is only meaningful when its zf flag is clear.
    always_comb begin
        for (int l = 0; l <= S; l++) begin
            for (int n = 0; n < P; n++) begin
                f_zf[l][n] = 1'b0;
                f_cn[l][n] = '0;
            end
        end
        for (int n = 0; n < P; n++) begin
            f_zf[0][n] = ~padded[n];
        end
        for (int l = 1; l <= S; l++) begin
            for (int n = 0; n < (P >> l); n++) begin
                f_zf[l][n] = f_zf[l-1][2*n+1] & f_zf[l-1][2*n];
                f_cn[l][n] = f_zf[l-1][2*n+1] ? (f_cn[l-1][2*n] | CW'(1 << (l - 1)))
                                              : f_cn[l-1][2*n+1];
            end
        end
    end

`ifdef LZC_PIPE_EN
    logic mid_valid;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            mid_valid <= 1'b0;
        end else begin
            mid_valid <= valid_i;
            if (valid_i) begin
                for (int n = 0; n < P; n++) begin
                    mid_zf[n] <= f_zf[S][n];
                    mid_cn[n] <= f_cn[S][n];
                end
            end
        end
    end

    assign stage_valid = mid_valid;
`else
    always_comb begin
        for (int n = 0; n < P; n++) begin
            mid_zf[n] = f_zf[S][n];
            mid_cn[n] = f_cn[S][n];
        end
    end

    assign stage_valid = valid_i;
`endif

    // Row k of the back half of the tree is tree level S+k.
    always_comb begin
        for (int k = 0; k < NB; k++) begin
            for (int n = 0; n < P; n++) begin
                b_zf[k][n] = 1'b0;
                b_cn[k][n] = '0;
            end
        end
        for (int n = 0; n < P; n++) begin
            b_zf[0][n] = mid_zf[n];
            b_cn[0][n] = mid_cn[n];
        end
        for (int k = 1; k < NB; k++) begin
            for (int n = 0; n < (P >> (S + k)); n++) begin
                b_zf[k][n] = b_zf[k-1][2*n+1] & b_zf[k-1][2*n];
                b_cn[k][n] = b_zf[k-1][2*n+1] ? (b_cn[k-1][2*n] | CW'(1 << (S + k - 1)))
                                              : b_cn[k-1][2*n+1];
            end
        end
        cnt_full = b_zf[NB-1][0] ? CW'(P) : b_cn[NB-1][0];
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            valid_o <= 1'b0;
            cnt_o   <= '0;
            zero_o  <= 1'b0;
        end else begin
            valid_o <= stage_valid;
            if (stage_valid) begin
                cnt_o  <= CNT_W'(cnt_full);
                zero_o <= (cnt_full == CW'(W));
            end
        end
    end

endmodule

// File: tb/tb_lzc.sv
// Table-driven and model-checked bench for lzc at W=12, plus W=16 and W=5 instances for the random regression.
module tb_lzc;

`ifdef LZC_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        nreset;
    logic        valid_i;
    logic [11:0] d12;
    logic [15:0] d16;
    logic [4:0]  d5;
    logic        v12, v16, v5;
    logic [3:0]  c12;
    logic [4:0]  c16;
    logic [2:0]  c5;
    logic        z12, z16, z5;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference pipeline: index LAT-1 mirrors the output registers.
    logic sv  [2];
    int   e12 [2];
    int   e16 [2];
    int   e5  [2];

    typedef struct {
        logic [11:0] data;
        logic [3:0]  cnt;
        logic        zero;
    } vec_t;

    vec_t vecs [25];

    lzc #(.W(12)) dut12 (.clk(clk), .nreset(nreset), .valid_i(valid_i), .data_i(d12),
                         .valid_o(v12), .cnt_o(c12), .zero_o(z12));
    lzc #(.W(16)) dut16 (.clk(clk), .nreset(nreset), .valid_i(valid_i), .data_i(d16),
                         .valid_o(v16), .cnt_o(c16), .zero_o(z16));
    lzc #(.W(5))  dut5  (.clk(clk), .nreset(nreset), .valid_i(valid_i), .data_i(d5),
                         .valid_o(v5), .cnt_o(c5), .zero_o(z5));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int lz_ref(input logic [15:0] d, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            if (d[i]) return w - 1 - i;
        end
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep(input logic v, input logic [11:0] a, input logic [15:0] b,
                             input logic [4:0] c, input logic rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) sv[i] = 1'b0;
            e12[LAT-1] = 0;
            e16[LAT-1] = 0;
            e5[LAT-1]  = 0;
        end else begin
            for (int i = LAT - 1; i >= 1; i--) begin
                if (sv[i-1]) begin
                    e12[i] = e12[i-1];
                    e16[i] = e16[i-1];
                    e5[i]  = e5[i-1];
                end
                sv[i] = sv[i-1];
            end
            sv[0] = v;
            if (v) begin
                e12[0] = lz_ref({4'h0, a}, 12);
                e16[0] = lz_ref(b, 16);
                e5[0]  = lz_ref({11'h0, c}, 5);
            end
        end
    endtask

    task automatic checkModel();
        checkOutput("valid12", 8'(v12), 8'(sv[LAT-1]));
        checkOutput("cnt12",   8'(c12), 8'(e12[LAT-1]));
        checkOutput("zero12",  8'(z12), 8'(e12[LAT-1] == 12));
        checkOutput("valid16", 8'(v16), 8'(sv[LAT-1]));
        checkOutput("cnt16",   8'(c16), 8'(e16[LAT-1]));
        checkOutput("zero16",  8'(z16), 8'(e16[LAT-1] == 16));
        checkOutput("valid5",  8'(v5),  8'(sv[LAT-1]));
        checkOutput("cnt5",    8'(c5),  8'(e5[LAT-1]));
        checkOutput("zero5",   8'(z5),  8'(e5[LAT-1] == 5));
    endtask

    // One clock: drive inputs, step the model at the edge, compare #1 later.
    task automatic applyStimulus(input logic v, input logic [11:0] a, input logic [15:0] b,
                                 input logic [4:0] c, input logic rst_n);
        valid_i = v;
        d12     = a;
        d16     = b;
        d5      = c;
        nreset  = rst_n;
        @(posedge clk);
        modelStep(v, a, b, c, rst_n);
        #1;
        checkModel();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 'x, 'x, 'x, 1'b1);
    endtask

    logic [11:0] stream_d   [4];
    int          stream_exp [4];
    logic [11:0] r12;
    logic [15:0] r16;
    logic [4:0]  r5;

    initial begin
        for (int i = 0; i <= 12; i++) begin
            vecs[i].data = 12'hFFF >> i;
            vecs[i].cnt  = 4'(i);
            vecs[i].zero = (i == 12);
        end
        vecs[13] = '{12'h001, 4'd11, 1'b0};
        vecs[14] = '{12'h002, 4'd10, 1'b0};
        vecs[15] = '{12'h004, 4'd9,  1'b0};
        vecs[16] = '{12'h008, 4'd8,  1'b0};
        vecs[17] = '{12'h010, 4'd7,  1'b0};
        vecs[18] = '{12'h020, 4'd6,  1'b0};
        vecs[19] = '{12'h040, 4'd5,  1'b0};
        vecs[20] = '{12'h080, 4'd4,  1'b0};
        vecs[21] = '{12'h100, 4'd3,  1'b0};
        vecs[22] = '{12'h200, 4'd2,  1'b0};
        vecs[23] = '{12'h400, 4'd1,  1'b0};
        vecs[24] = '{12'h800, 4'd0,  1'b0};
        stream_d   = '{12'h800, 12'h000, 12'h001, 12'h0F0};
        stream_exp = '{0, 12, 11, 4};
        for (int i = 0; i < 2; i++) begin
            sv[i] = 1'b0; e12[i] = 0; e16[i] = 0; e5[i] = 0;
        end

        repeat (3) applyStimulus(1'b0, 'x, 'x, 'x, 1'b0);
        checkOutput("reset_valid", 8'(v12), 8'd0);
        checkOutput("reset_cnt",   8'(c12), 8'd0);
        checkOutput("reset_zero",  8'(z12), 8'd0);

        for (int i = 0; i < 25; i++) begin
            applyStimulus(1'b1, vecs[i].data, 16'($urandom), 5'($urandom), 1'b1);
            repeat (LAT - 1) idle();
            checkOutput($sformatf("vec%0d_valid", i), 8'(v12), 8'd1);
            checkOutput($sformatf("vec%0d_cnt", i),   8'(c12), 8'(vecs[i].cnt));
            checkOutput($sformatf("vec%0d_zero", i),  8'(z12), 8'(vecs[i].zero));
        end
        idle();

        for (int k = 0; k < 4 + LAT; k++) begin
            if (k < 4) applyStimulus(1'b1, stream_d[k], 16'($urandom), 5'($urandom), 1'b1);
            else       idle();
            if (k - (LAT - 1) >= 0 && k - (LAT - 1) < 4) begin
                checkOutput("stream_valid", 8'(v12), 8'd1);
                checkOutput("stream_cnt",   8'(c12), 8'(stream_exp[k-(LAT-1)]));
            end else if (k - (LAT - 1) == 4) begin
                checkOutput("stream_end", 8'(v12), 8'd0);
            end
        end

        applyStimulus(1'b1, 12'h0F0, 16'h00F0, 5'h04, 1'b1);
        idle();
        applyStimulus(1'b1, 12'h001, 16'h0001, 5'h01, 1'b1);
        if (LAT == 2) begin
            checkOutput("gap_valid", 8'(v12), 8'd0);
            checkOutput("gap_hold",  8'(c12), 8'd4);
        end
        repeat (LAT - 1) idle();
        checkOutput("gap_last_valid", 8'(v12), 8'd1);
        checkOutput("gap_last_cnt",   8'(c12), 8'd11);
        idle();
        checkOutput("gap_drop", 8'(v12), 8'd0);
        checkOutput("gap_hold2", 8'(c12), 8'd11);

        applyStimulus(1'b1, 12'h0F0, 16'h0F00, 5'h03, 1'b1);
        applyStimulus(1'b1, 12'h003, 16'h0003, 5'h01, 1'b1);
        applyStimulus(1'b1, 12'h800, 16'h8000, 5'h10, 1'b0);
        checkOutput("rst_mid_valid", 8'(v12), 8'd0);
        checkOutput("rst_mid_cnt",   8'(c12), 8'd0);
        for (int k = 0; k < 3; k++) begin
            idle();
            checkOutput("rst_no_stale", 8'(v12), 8'd0);
        end
        applyStimulus(1'b1, 12'h00F, 16'h000F, 5'h02, 1'b1);
        repeat (LAT - 1) idle();
        checkOutput("post_rst_valid", 8'(v12), 8'd1);
        checkOutput("post_rst_cnt",   8'(c12), 8'd8);

        for (int k = 0; k < 10000; k++) begin
            r12 = 12'($urandom) >> $urandom_range(0, 12);
            r16 = 16'($urandom) >> $urandom_range(0, 16);
            r5  = 5'($urandom) >> $urandom_range(0, 5);
            if ($urandom_range(0, 7) != 0) applyStimulus(1'b1, r12, r16, r5, 1'b1);
            else                           idle();
        end
        repeat (LAT) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lzc.md
LZC -- requirements
Module: lzc

Interface
REQ-001 The block SHALL have parameter W, default 12, giving the input data width in bits; legal range 2..64.
REQ-002 The block SHALL have parameter CNT_W, default $clog2(W+1), giving the count width; for W=12 this is 4.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port nreset  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 Port valid_i  input  1  SHALL qualify data_i for the current cycle.
REQ-006 Port data_i  input  W  SHALL be the vector to count; bit W-1 is the MSB.
REQ-007 Port valid_o  output  1  SHALL qualify cnt_o and zero_o.
REQ-008 Port cnt_o  output  CNT_W  SHALL carry the leading-zero count of the qualified input.
REQ-009 Port zero_o  output  1  SHALL be high when the qualified input was all zeros.

Function
REQ-010 cnt_o SHALL equal the number of consecutive 0 bits in data_i, starting at bit W-1 and moving toward bit 0, up to the first 1.
REQ-011 data_i = all ones (any value with bit W-1 = 1) SHALL give cnt_o = 0.
REQ-012 data_i = all zeros SHALL give cnt_o = W and zero_o = 1; any other input SHALL give zero_o = 0.
REQ-013 The count SHALL be computed by a binary tree of 2-bit leading-zero/all-zero cells, merged level by level. W not a power of two SHALL be padded with ones at the LSB side to the next power of two. Padding SHALL NOT affect results for inputs of width W.
REQ-014 Latency SHALL be exactly 1 clk cycle from valid_i sampled high to valid_o high with the matching cnt_o and zero_o (LZC_PIPE_EN undefined).
REQ-015 valid_o SHALL be valid_i delayed by the pipeline latency, cycle for cycle. Back-to-back valid_i SHALL be accepted every cycle with no stalls.
REQ-016 When valid_i is low, the pipeline data registers SHALL hold their values and valid_o SHALL drop after the latency. cnt_o and zero_o SHALL keep their last values while valid_o is low.
REQ-017 data_i SHALL be ignored when valid_i is low, including X values, with no effect on outputs.
REQ-018 The block SHALL have no backpressure input; outputs SHALL be consumed in the cycle valid_o is high.

Reset
REQ-019 When nreset is low at a rising clk edge, valid_o, cnt_o and zero_o SHALL all be 0 from the next cycle onward.
REQ-020 Reset mid-operation SHALL discard every in-flight input; no valid_o pulse SHALL appear for inputs sampled before or during reset.
REQ-021 The first input accepted after nreset returns high SHALL produce a correct result after the normal latency.

Configuration
REQ-022 Macro LZC_PIPE_EN, when defined, SHALL insert a register stage at the midpoint level of the merge tree, with its own valid bit, making latency exactly 2 cycles.
REQ-023 Without LZC_PIPE_EN, the tree SHALL be purely combinational between the input and the output registers, with latency 1.
REQ-024 Both builds SHALL give identical output sequences apart from the latency offset. Reset SHALL clear the extra stage's valid bit to 0.

Verification
REQ-025 Thermometer sweep, W=12:
- data_i=0xFFF -> cnt_o=0.
- For i=1..11, data_i with i leading zeros followed by ones (e.g. 0x0FF -> cnt_o=4) -> cnt_o=i, zero_o=0.
- data_i=0x000 -> cnt_o=12, zero_o=1.
REQ-026 One-hot sweep: data_i=1<<k for k=0..11 -> cnt_o=11-k. Include 0x001 -> 11 and 0x800 -> 0.
REQ-027 Back-to-back stream 0x800, 0x000, 0x001, 0x0F0 with valid_i held high -> valid_o high for 4 consecutive cycles with cnt_o=0, 12, 11, 4, at latency 1 (or 2 with LZC_PIPE_EN).
REQ-028 Gapped valid: valid_i pattern 1,0,1 with data_i=X in the gap -> valid_o pattern 1,0,1, and cnt_o holds its value during the gap.
REQ-029 Reset mid-stream: nreset low for 1 cycle while 2 inputs are in flight -> valid_o=0 and cnt_o=0 the next cycle, and no stale results afterward.
REQ-030 Random regression: 10000 random data_i, including values biased to many leading zeros -> cnt_o and zero_o match a reference model, checked at W=12, W=16 and W=5.
